// File: rtl/aer_receiver.sv
// aer_receiver: receiving end of the two-bit AER four-phase link.
// Synchronises req/address, settles, decodes one spike pulse per handshake,
// and keeps saturating per-output event counters plus a sticky error flag.
module aer_receiver #(
  parameter int SETTLE_CYCLES = 2,  // legal range 1..15
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             bit0,
  input  logic             bit1,
  output logic             ack,
  output logic             Ch1Up,
  output logic             Ch1Down,
  output logic             Ch2Up,
  output logic             Ch2Down,
  output logic             busy,
  output logic             err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ch1up_cnt,
  output logic [CNT_W-1:0] ch1down_cnt,
  output logic [CNT_W-1:0] ch2up_cnt,
  output logic [CNT_W-1:0] ch2down_cnt
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // Synchroniser chains; index 1 is the stage the rest of the logic uses.
  logic [1:0] req_sync_reg;
  logic [1:0] a0_sync_reg;
  logic [1:0] a1_sync_reg;
  logic       req_s;
  logic       a0_s;
  logic       a1_s;
  logic [1:0] addr_s;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] settle_reg;
  logic [3:0] settle_next;
  logic       fire;
  logic       glitch;

  logic       ack_reg;
  logic       ack_next;
  logic [3:0] pulse_reg;
  logic [3:0] pulse_next;
  logic       err_reg;
  logic       err_next;

  logic [3:0][CNT_W-1:0] cnt_vec;

  assign req_s  = req_sync_reg[1];
  assign a0_s   = a0_sync_reg[1];
  assign a1_s   = a1_sync_reg[1];
  assign addr_s = {a1_s, a0_s};

  // Two-flop synchronisers for the three asynchronous link inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_sync_reg <= 2'b00;
      a0_sync_reg  <= 2'b00;
      a1_sync_reg  <= 2'b00;
    end else begin
      req_sync_reg <= {req_sync_reg[0], req};
      a0_sync_reg  <= {a0_sync_reg[0], bit0};
      a1_sync_reg  <= {a1_sync_reg[0], bit1};
    end
  end

  // FSM state and settle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      settle_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
    end
  end

  // Next-state logic; the event is taken on the edge where the settle
  // counter steps from 1 to 0 with the request still asserted.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    fire        = 1'b0;
    glitch      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_s) begin
          state_next  = SETTLE;
          settle_next = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (!req_s) begin
          glitch      = 1'b1;
          state_next  = IDLE;
          settle_next = 4'd0;
        end else if (settle_reg <= 4'd1) begin
          fire        = 1'b1;
          state_next  = WAIT_REL;
          settle_next = 4'd0;
        end else begin
          settle_next = settle_reg - 4'd1;
        end
      end
      WAIT_REL: begin
        if (!req_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        settle_next = 4'd0;
      end
    endcase
  end

  // Output decode: ack tracks residency in WAIT_REL, pulses decode the
  // captured address only on the capture edge, err is sticky.
  always_comb begin
    ack_next   = (state_next == WAIT_REL);
    pulse_next = 4'b0000;
    if (fire) begin
      pulse_next = 4'b0001 << addr_s;
    end
    // A coinciding glitch wins over the clear so the error is never lost.
    err_next = glitch | (err_reg & ~cnt_clr);
  end

  // Registered handshake, pulse and error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_reg   <= 1'b0;
      pulse_reg <= 4'b0000;
      err_reg   <= 1'b0;
    end else begin
      ack_reg   <= ack_next;
      pulse_reg <= pulse_next;
      err_reg   <= err_next;
    end
  end

  // One saturating counter per decoded output.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      // Clear and increment in the same cycle leaves the counter at 1.
      always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
          cnt_next = pulse_next[gi] ? CNT_ONE : '0;
        end else if (pulse_next[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      // Counter register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign ack         = ack_reg;
  assign Ch1Up       = pulse_reg[0];
  assign Ch1Down     = pulse_reg[1];
  assign Ch2Up       = pulse_reg[2];
  assign Ch2Down     = pulse_reg[3];
  assign busy        = (state_reg != IDLE);
  assign err         = err_reg;
  assign ch1up_cnt   = cnt_vec[0];
  assign ch1down_cnt = cnt_vec[1];
  assign ch2up_cnt   = cnt_vec[2];
  assign ch2down_cnt = cnt_vec[3];

endmodule
